// File: rtl/display_demultiplex_pkg.sv
// Shared constants for reading back the multiplexed 7-segment display bus.
package display_demultiplex_pkg;

   // Digits on the multiplexed bus, one cathode line each.
   localparam int unsigned NUM_DIGITS = 8;

   // Segment patterns, bit0 = a .. bit6 = g, active high.
   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_A     = 7'h77;
   localparam logic [6:0] SEG_B     = 7'h7C;
   localparam logic [6:0] SEG_C     = 7'h39;
   localparam logic [6:0] SEG_D     = 7'h5E;
   localparam logic [6:0] SEG_E     = 7'h79;
   localparam logic [6:0] SEG_F     = 7'h71;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   typedef enum logic [1:0] {
      StIdle,
      StSettle,
      StHold
   } state_e;

   // Clock cycles that make up the stall timeout.
   function automatic int unsigned timeout_cycles(input int unsigned clock_hz,
                                                  input int unsigned timeout_us);
      return (clock_hz / 1_000_000) * timeout_us;
   endfunction

endpackage

// File: rtl/seg7_reverse_decoder.sv
// Inverse of the 7-segment decoder: segment pattern back to a hex nibble.
module seg7_reverse_decoder
   import display_demultiplex_pkg::*;
(
   input  logic [6:0] i_segments,
   output logic [3:0] o_nibble,
   output logic       o_blank,
   output logic       o_invalid
);

   // Pattern lookup; dark digit reads as 0 without flagging an error.
   always_comb begin
      o_nibble  = 4'h0;
      o_blank   = 1'b0;
      o_invalid = 1'b0;
      case (i_segments)
         SEG_0:     o_nibble = 4'h0;
         SEG_1:     o_nibble = 4'h1;
         SEG_2:     o_nibble = 4'h2;
         SEG_3:     o_nibble = 4'h3;
         SEG_4:     o_nibble = 4'h4;
         SEG_5:     o_nibble = 4'h5;
         SEG_6:     o_nibble = 4'h6;
         SEG_7:     o_nibble = 4'h7;
         SEG_8:     o_nibble = 4'h8;
         SEG_9:     o_nibble = 4'h9;
         SEG_A:     o_nibble = 4'hA;
         SEG_B:     o_nibble = 4'hB;
         SEG_C:     o_nibble = 4'hC;
         SEG_D:     o_nibble = 4'hD;
         SEG_E:     o_nibble = 4'hE;
         SEG_F:     o_nibble = 4'hF;
         SEG_BLANK: o_blank  = 1'b1;
         default:   o_invalid = 1'b1;
      endcase
   end

endmodule

// File: rtl/display_demultiplex.sv
// Rebuilds the displayed hex value, decimal points and blanking from the
// multiplexed cathode/segment bus. Bus inputs are asynchronous to Clock.
module display_demultiplex
   import display_demultiplex_pkg::*;
#(
   parameter int unsigned CLOCK_HZ      = 10_000_000,
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned TIMEOUT_US    = 10_000
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [7:0]  Cathodes_i,
   input  logic [7:0]  Segments_i,
   output logic [31:0] Data_o,
   output logic [7:0]  DecimalPoints_o,
   output logic [7:0]  Blank_o,
   output logic        Valid_o,
   output logic        FrameError_o,
   output logic        Stalled_o
);

   localparam logic [7:0]  SettleTarget = 8'(SETTLE_CYCLES);
   localparam logic [31:0] TimeoutLimit = 32'(timeout_cycles(CLOCK_HZ, TIMEOUT_US));

   logic [7:0]  r_cath_meta, r_cath_sync;
   logic [7:0]  r_seg_meta, r_seg_sync;
   logic [7:0]  r_seg_prev;
   logic [7:0]  r_sel;
   logic [7:0]  r_settle_cnt;
   state_e      r_state;

   logic [31:0] r_data;
   logic [7:0]  r_dp;
   logic [7:0]  r_blank;
   logic [7:0]  r_mask;
   logic        r_err;
   logic        r_publish;
   logic [31:0] r_to_cnt;

   logic        w_stable;
   logic        w_sample;
   logic [7:0]  w_mask_base;
   logic [7:0]  w_mask_next;
   logic [3:0]  w_nibble;
   logic        w_blank;
   logic        w_invalid;

   seg7_reverse_decoder u_decoder (
      .i_segments (r_seg_sync[6:0]),
      .o_nibble   (w_nibble),
      .o_blank    (w_blank),
      .o_invalid  (w_invalid)
   );

   // Two-flop synchronizers for both bus groups.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_cath_meta <= '0;
         r_cath_sync <= '0;
         r_seg_meta  <= '0;
         r_seg_sync  <= '0;
      end else begin
         r_cath_meta <= Cathodes_i;
         r_cath_sync <= r_cath_meta;
         r_seg_meta  <= Segments_i;
         r_seg_sync  <= r_seg_meta;
      end
   end

   // Stability check and sample strobe; mask restarts on the publish cycle.
   always_comb begin
      w_stable    = (r_cath_sync == r_sel) && (r_seg_sync == r_seg_prev);
      w_sample    = (r_state == StSettle) && w_stable && (r_settle_cnt == SettleTarget);
      w_mask_base = r_publish ? 8'h00 : r_mask;
      w_mask_next = w_mask_base | r_sel;
   end

   // Digit-select FSM: wait for one-hot cathode, settle, sample once, hold.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_state      <= StIdle;
         r_sel        <= '0;
         r_settle_cnt <= '0;
         r_seg_prev   <= '0;
      end else begin
         r_seg_prev <= r_seg_sync;
         unique case (r_state)
            StIdle: begin
               if ($onehot(r_cath_sync)) begin
                  r_state      <= StSettle;
                  r_settle_cnt <= 8'd1;
                  r_sel        <= r_cath_sync;
               end
            end
            StSettle: begin
               if (!w_stable) begin
                  r_settle_cnt <= 8'd1;
                  r_sel        <= r_cath_sync;
                  if (!$onehot(r_cath_sync)) begin
                     r_state <= StIdle;
                  end
               end else if (w_sample) begin
                  r_state <= StHold;
               end else begin
                  r_settle_cnt <= r_settle_cnt + 8'd1;
               end
            end
            StHold: begin
               // Leaving a digit is evaluated like IDLE in the same cycle.
               if (r_cath_sync != r_sel) begin
                  r_sel        <= r_cath_sync;
                  r_settle_cnt <= 8'd1;
                  r_state      <= $onehot(r_cath_sync) ? StSettle : StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   // Per-digit capture and frame accumulation.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_data    <= '0;
         r_dp      <= '0;
         r_blank   <= '0;
         r_mask    <= '0;
         r_err     <= 1'b0;
         r_publish <= 1'b0;
      end else begin
         r_publish <= w_sample && (w_mask_next == 8'hFF);
         if (w_sample) begin
            for (int n = 0; n < NUM_DIGITS; n++) begin
               if (r_sel[n]) begin
                  r_data[4*n +: 4] <= w_nibble;
                  r_dp[n]          <= r_seg_sync[7];
                  r_blank[n]       <= w_blank;
               end
            end
            r_mask <= w_mask_next;
            r_err  <= (r_publish ? 1'b0 : r_err) | w_invalid;
         end else if (r_publish) begin
            r_mask <= '0;
            r_err  <= 1'b0;
         end
      end
   end

   // Publish a completed frame; outputs hold until the next one.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         Data_o          <= '0;
         DecimalPoints_o <= '0;
         Blank_o         <= '0;
         FrameError_o    <= 1'b0;
         Valid_o         <= 1'b0;
      end else begin
         Valid_o <= r_publish;
         if (r_publish) begin
            Data_o          <= r_data;
            DecimalPoints_o <= r_dp;
            Blank_o         <= r_blank;
            FrameError_o    <= r_err;
         end
      end
   end

   // Stall watchdog: saturating cycle count since the last digit sample.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_to_cnt  <= '0;
         Stalled_o <= 1'b0;
      end else begin
         if (w_sample) begin
            r_to_cnt <= '0;
         end else if (r_to_cnt != TimeoutLimit) begin
            r_to_cnt <= r_to_cnt + 32'd1;
         end
         Stalled_o <= (r_to_cnt == TimeoutLimit);
      end
   end

endmodule

// File: tb/tb_display_demultiplex.sv
// Scoreboard bench: a bus model scans frames, a monitor checks each Valid_o.
module tb_display_demultiplex;

   localparam int unsigned ClockHz     = 1_000_000;
   localparam int unsigned Settle      = 4;
   localparam int unsigned TimeoutUs   = 300;
   localparam int          DigitCycles = 16;

   typedef struct {
      logic [31:0] data;
      logic [7:0]  dp;
      logic [7:0]  blank;
      logic        err;
   } frame_t;

   logic        Clock;
   logic        Reset;
   logic [7:0]  Cathodes_i;
   logic [7:0]  Segments_i;
   logic [31:0] Data_o;
   logic [7:0]  DecimalPoints_o;
   logic [7:0]  Blank_o;
   logic        Valid_o;
   logic        FrameError_o;
   logic        Stalled_o;

   int total = 0;
   int bad   = 0;
   frame_t exp_q[$];

   logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   display_demultiplex #(
      .CLOCK_HZ      (ClockHz),
      .SETTLE_CYCLES (Settle),
      .TIMEOUT_US    (TimeoutUs)
   ) dut (
      .Clock           (Clock),
      .Reset           (Reset),
      .Cathodes_i      (Cathodes_i),
      .Segments_i      (Segments_i),
      .Data_o          (Data_o),
      .DecimalPoints_o (DecimalPoints_o),
      .Blank_o         (Blank_o),
      .Valid_o         (Valid_o),
      .FrameError_o    (FrameError_o),
      .Stalled_o       (Stalled_o)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: every Valid_o must match the oldest expected frame.
   always @(negedge Clock) begin
      if (Reset && Valid_o) begin
         if (exp_q.size() == 0) begin
            check("unexpected_valid", 32'd1, 32'd0);
         end else begin
            frame_t e;
            e = exp_q.pop_front();
            check("data", Data_o, e.data);
            check("dp", 32'(DecimalPoints_o), 32'(e.dp));
            check("blank", 32'(Blank_o), 32'(e.blank));
            check("frame_error", 32'(FrameError_o), 32'(e.err));
         end
      end
   end

   // Scan n_digits digits (0 upward) with a dark gap between them.
   task automatic drive_frame(input logic [31:0] data, input logic [7:0] dp,
                              input logic [7:0] blk, input int n_digits,
                              input int bad_digit, input int glitch_digit, input logic push,
                              input logic [31:0] e_data, input logic [7:0] e_dp,
                              input logic [7:0] e_blank, input logic e_err);
      frame_t     e;
      logic [7:0] pat;
      logic [3:0] nib;
      if (push) begin
         e.data  = e_data;
         e.dp    = e_dp;
         e.blank = e_blank;
         e.err   = e_err;
         exp_q.push_back(e);
      end
      for (int d = 0; d < n_digits; d++) begin
         @(negedge Clock);
         Cathodes_i = 8'h00;
         repeat (2) @(negedge Clock);
         nib = data[4*d +: 4];
         if (blk[d]) pat = {dp[d], 7'h00};
         else        pat = {dp[d], seg_tab[nib]};
         if (d == bad_digit) pat = 8'h55;
         if (d == glitch_digit) begin
            Segments_i = 8'h55;
            Cathodes_i = 8'(1 << d);
            repeat (2) @(negedge Clock);
         end
         Segments_i = pat;
         Cathodes_i = 8'(1 << d);
         repeat (DigitCycles) @(negedge Clock);
      end
      Cathodes_i = 8'h00;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_data"}, Data_o, 32'h0);
      check({tag, "_dp"}, 32'(DecimalPoints_o), 32'h0);
      check({tag, "_blank"}, 32'(Blank_o), 32'h0);
      check({tag, "_valid"}, 32'(Valid_o), 32'h0);
      check({tag, "_err"}, 32'(FrameError_o), 32'h0);
      check({tag, "_stalled"}, 32'(Stalled_o), 32'h0);
   endtask

   initial begin
      int waited;
      Reset      = 1'b0;
      Cathodes_i = 8'h00;
      Segments_i = 8'h00;
      repeat (3) @(negedge Clock);
      check_all_zero("reset");
      Reset = 1'b1;

      // Plain frames, DP on digits 7 and 0; two frames give two Valid_o.
      drive_frame(32'h1234ABCD, 8'h81, 8'h00, 8, -1, -1, 1'b1,
                  32'h1234ABCD, 8'h81, 8'h00, 1'b0);
      drive_frame(32'h1234ABCD, 8'h81, 8'h00, 8, -1, -1, 1'b1,
                  32'h1234ABCD, 8'h81, 8'h00, 1'b0);
      // Leading-zero blanking.
      drive_frame(32'h000000A5, 8'h00, 8'hFC, 8, -1, -1, 1'b1,
                  32'h000000A5, 8'h00, 8'hFC, 1'b0);
      // Two-cycle invalid glitch at the start of digit 3 must not be sampled.
      drive_frame(32'h87654321, 8'h10, 8'h00, 8, -1, 3, 1'b1,
                  32'h87654321, 8'h10, 8'h00, 1'b0);
      // Undecodable 0x55 on digit 5, then a clean frame clears the error.
      drive_frame(32'hFEDC9876, 8'h00, 8'h00, 8, 5, -1, 1'b1,
                  32'hFE0C9876, 8'h00, 8'h00, 1'b1);
      drive_frame(32'h0F1E2D3C, 8'h00, 8'h00, 8, -1, -1, 1'b1,
                  32'h0F1E2D3C, 8'h00, 8'h00, 1'b0);
      check("stalled_while_scanning", 32'(Stalled_o), 32'h0);

      // Stall: no digit for longer than the timeout.
      Cathodes_i = 8'h00;
      repeat (TimeoutUs + 20) @(negedge Clock);
      check("stalled_set", 32'(Stalled_o), 32'h1);
      check("stalled_keeps_outputs", Data_o, 32'h0F1E2D3C);
      drive_frame(32'h13579BDF, 8'hAA, 8'h00, 8, -1, -1, 1'b1,
                  32'h13579BDF, 8'hAA, 8'h00, 1'b0);
      check("stalled_cleared", 32'(Stalled_o), 32'h0);

      // Reset after five digits; the partial frame must be discarded.
      drive_frame(32'h11111111, 8'hFF, 8'h00, 5, -1, -1, 1'b0,
                  32'h0, 8'h00, 8'h00, 1'b0);
      @(negedge Clock);
      Reset = 1'b0;
      repeat (2) @(negedge Clock);
      check_all_zero("midframe_reset");
      Reset = 1'b1;
      drive_frame(32'h2468ACE0, 8'h42, 8'h00, 8, -1, -1, 1'b1,
                  32'h2468ACE0, 8'h42, 8'h00, 1'b0);

      waited = 0;
      while (exp_q.size() != 0 && waited < 100) begin
         @(negedge Clock);
         waited++;
      end
      check("frames_outstanding", 32'(exp_q.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/display_demultiplex.md
Name: display_demultiplex

Overview:
Reader for the multiplexed 7-segment bus: samples the 8 one-hot cathode lines and 8 segment lines driven by the display multiplexer and rebuilds the displayed 32-bit hex value, decimal points and blanking mask. Used for board-to-board display capture and as a self-check monitor on our own display outputs. Inputs are asynchronous to Clock.

Parameters:
CLOCK_HZ, 10_000_000, Clock frequency in Hz.
SETTLE_CYCLES, 4, consecutive stable synchronized cycles required before a digit is sampled (1..255).
TIMEOUT_US, 10_000, time with no valid digit capture before Stalled_o asserts.

Ports:
Clock  input  1  system clock
Reset  input  1  asynchronous, active-low reset
Cathodes_i  input  8  active-high one-hot digit select; bit n = digit n, digit 0 rightmost
Segments_i  input  8  bit7 = DP, bits 6:0 = g..a, active high (common cathode)
Data_o  output  32  captured value, nibble n = digit n
DecimalPoints_o  output  8  captured DP per digit
Blank_o  output  8  1 = digit n was dark (segments 6:0 all zero)
Valid_o  output  1  one-cycle strobe: new frame on Data_o, DecimalPoints_o, Blank_o, FrameError_o
FrameError_o  output  1  published frame contained at least one undecodable pattern
Stalled_o  output  1  no capture for TIMEOUT_US

Behaviour:
- Reset: all outputs 0, synchronizers 0, captured-digit mask 0, FSM IDLE, timeout counter 0. Reset mid-frame discards partial frame; no Valid_o until a complete post-reset frame.
- Cathodes_i and Segments_i each pass through a 2-flop synchronizer; all logic below uses synchronized copies (Cs, Ss).
- FSM:
  IDLE: Cs exactly one-hot -> SETTLE, cnt=1, remember Cs. Otherwise stay.
  SETTLE: Cs and Ss unchanged vs previous cycle -> cnt++; any change -> cnt=1, remembered Cs updated (stay SETTLE if still one-hot, else IDLE). cnt == SETTLE_CYCLES -> sample, go HOLD.
  HOLD: stay while Cs unchanged; on any Cs change -> IDLE evaluation the same cycle (one-hot -> SETTLE).
- Sample of digit n: nibble[n] from segment decode, dp[n] = Ss[7], blank[n] = (Ss[6:0]==0), mask[n]=1. Resampling a digit already in mask overwrites it.
- Segment decode (bit0=a..bit6=g): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71; 00 = blank -> nibble 0, not an error. Any other pattern -> nibble 0, frame error flag set.
- Frame completion: cycle a sample makes mask = FF -> next cycle Data_o/DecimalPoints_o/Blank_o/FrameError_o update and Valid_o=1 for one cycle; mask and error flag clear the same cycle. Outputs hold between frames.
- Pin-to-sample latency: 2 sync cycles + SETTLE_CYCLES; Valid_o one cycle after the 8th sample.
- Cs zero or multi-hot: no sampling, no error (ghosting during switch is legal).
- Timeout: counter of Clock cycles, limit CLOCK_HZ/1_000_000*TIMEOUT_US; cleared on each sample; saturates at limit with Stalled_o=1; Stalled_o clears on the cycle after the next sample. Stall does not clear mask.

Decomposition:
- Shared package/include: segment pattern constants (SEG_0..SEG_F, SEG_BLANK), digit count 8, timeout-cycle computation.
- One sub-module: seg7_reverse_decoder (combinational, Segments[6:0] -> Nibble[3:0], Blank, Invalid), reusable inverse of the existing 7-seg decoder.

Test Plan:
- Drive the display multiplexer model with Data 0x1234ABCD, DP 0x81, 1000 us/digit -> Valid_o pulses each 8-digit frame, Data_o=0x1234ABCD, DecimalPoints_o=0x81, Blank_o=00, FrameError_o=0.
- Data 0x000000A5 with leading-zero blanking -> Data_o=0x000000A5, Blank_o=0xFC, FrameError_o=0.
- 2-cycle glitch on Segments_i during digit 3 with SETTLE_CYCLES=4 -> sampled value is the stable pattern after the glitch; frame correct.
- Digit 5 driven with pattern 0x55 -> Data_o[23:20]=0, FrameError_o=1 with Valid_o; next clean frame FrameError_o=0.
- Hold Cathodes_i=0 for TIMEOUT_US+1 us -> Stalled_o=1; resume scanning -> Stalled_o=0 after first sample, Valid_o once 8 digits captured.
- Assert Reset after 5 digits of a frame -> all outputs 0; first Valid_o only after 8 fresh digits post-reset.
